// File: rtl/rr_grant_encoder.sv
// Round-robin grant encoder for 4 requesters with bounded hold and idle gap.
// Ports: clk, rst, req[3:0], done -> grant_idx[1:0], grant_valid, ptr_out[1:0].
module rr_grant_encoder #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic [1:0] ptr_out
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int HL = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST = HL[CNT_W-1:0];

  logic [0:0]       state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       pick;
  logic             timeout;
  logic             release_now;

  // Scan from the far end so the candidate closest to ptr wins.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
  end

  assign timeout     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_now = done || !req[grant_idx] || timeout;
  assign ptr_out     = ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= 2'd0;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant_idx   <= pick;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr         <= grant_idx + 2'd1;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
